// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one MOV/MOC memory port between
// instruction fetch and data load/store, with alignment and timeout checks.
module mem_access_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_moc,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_moc,
    output logic        d_err,
    output logic        m_mov,
    output logic        m_rw,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_moc,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RELEASE,
        ERR
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [1:0] G_I = 2'b01;
    localparam logic [1:0] G_D = 2'b10;

    state_t        state, state_n;
    logic          last_d, last_d_n;
    logic [CW-1:0] cnt, cnt_n;

    logic [31:0] i_rdata_n, d_rdata_n;
    logic        i_moc_n, i_err_n, d_moc_n, d_err_n;
    logic        m_mov_n, m_rw_n;
    logic [1:0]  m_size_n;
    logic [31:0] m_addr_n, m_wdata_n;
    logic [1:0]  grant_n;
    logic        busy_n;

    logic pick_i;
    logic i_fault;
    logic d_fault;

    always_comb begin
        d_fault = 1'b1;
        case (d_size)
            2'b00:   d_fault = 1'b0;
            2'b01:   d_fault = d_addr[0];
            2'b10:   d_fault = |d_addr[1:0];
            default: d_fault = 1'b1;
        endcase
    end

    // I wins a tie unless it was the last successful owner
    assign pick_i  = i_req && (!d_req || last_d);
    assign i_fault = |i_addr[1:0];

    always_comb begin
        state_n   = state;
        last_d_n  = last_d;
        cnt_n     = cnt;
        i_rdata_n = i_rdata;
        d_rdata_n = d_rdata;
        i_moc_n   = 1'b0;
        i_err_n   = 1'b0;
        d_moc_n   = 1'b0;
        d_err_n   = 1'b0;
        m_mov_n   = m_mov;
        m_rw_n    = m_rw;
        m_size_n  = m_size;
        m_addr_n  = m_addr;
        m_wdata_n = m_wdata;
        grant_n   = grant;

        unique case (state)
            IDLE: begin
                if (pick_i) begin
                    grant_n = G_I;
                    if (i_fault) begin
                        i_err_n = 1'b1;
                        state_n = ERR;
                    end else begin
                        m_mov_n   = 1'b1;
                        m_rw_n    = 1'b1;
                        m_size_n  = 2'b10;
                        m_addr_n  = i_addr;
                        m_wdata_n = '0;
                        last_d_n  = 1'b0;
                        cnt_n     = '0;
                        state_n   = WAIT;
                    end
                end else if (d_req) begin
                    grant_n = G_D;
                    if (d_fault) begin
                        d_err_n = 1'b1;
                        state_n = ERR;
                    end else begin
                        m_mov_n   = 1'b1;
                        m_rw_n    = d_rw;
                        m_size_n  = d_size;
                        m_addr_n  = d_addr;
                        m_wdata_n = d_wdata;
                        last_d_n  = 1'b1;
                        cnt_n     = '0;
                        state_n   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (m_moc) begin
                    m_mov_n = 1'b0;
                    state_n = RELEASE;
                    if (grant == G_D) begin
                        d_moc_n = 1'b1;
                        if (m_rw) d_rdata_n = m_rdata;
                    end else begin
                        i_moc_n = 1'b1;
                        if (m_rw) i_rdata_n = m_rdata;
                    end
                end else if ((TIMEOUT > 0) && (cnt == LIM)) begin
                    m_mov_n = 1'b0;
                    state_n = RELEASE;
                    if (grant == G_D) d_err_n = 1'b1;
                    else              i_err_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            // a MOC still high here belongs to the finished access
            RELEASE: begin
                if (!m_moc) begin
                    state_n = IDLE;
                    grant_n = '0;
                end
            end
            ERR: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            last_d  <= 1'b1;
            cnt     <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_moc   <= 1'b0;
            i_err   <= 1'b0;
            d_moc   <= 1'b0;
            d_err   <= 1'b0;
            m_mov   <= 1'b0;
            m_rw    <= 1'b0;
            m_size  <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            grant   <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            last_d  <= last_d_n;
            cnt     <= cnt_n;
            i_rdata <= i_rdata_n;
            d_rdata <= d_rdata_n;
            i_moc   <= i_moc_n;
            i_err   <= i_err_n;
            d_moc   <= d_moc_n;
            d_err   <= d_err_n;
            m_mov   <= m_mov_n;
            m_rw    <= m_rw_n;
            m_size  <= m_size_n;
            m_addr  <= m_addr_n;
            m_wdata <= m_wdata_n;
            grant   <= grant_n;
            busy    <= busy_n;
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed sequences, a vector table and
// random traffic checked by a transaction-level scoreboard.
module tb_mem_access_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_moc, i_err;
    logic        d_req = 1'b0;
    logic        d_rw = 1'b1;
    logic [1:0]  d_size = 2'b10;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_moc, d_err;
    logic        m_mov, m_rw;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_moc = 1'b0;
    logic [1:0]  grant;
    logic        busy;

    always #5 clk = ~clk;

    mem_access_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_moc(i_moc), .i_err(i_err),
        .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_moc(d_moc), .d_err(d_err),
        .m_mov(m_mov), .m_rw(m_rw), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_moc(m_moc),
        .grant(grant), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // memory model: answers after a latency, drops MOC once MOV is gone
    bit          mem_silent = 0;
    bit          mem_force = 0;
    bit          mem_ovr_en = 0;
    logic [31:0] mem_ovr = '0;
    int          mem_lat = -1;
    int          mem_cnt = 0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return mem_ovr_en ? mem_ovr : {a[15:0] ^ 16'hA5A5, ~a[15:0]};
    endfunction

    always @(negedge clk) begin
        if (!m_mov) begin
            m_moc = mem_force;
            mem_cnt = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 3));
        end else if (!mem_silent && !m_moc) begin
            if (mem_cnt == 0) begin
                m_moc = 1'b1;
                m_rdata = mem_val(m_addr);
            end else begin
                mem_cnt--;
            end
        end
    end

    logic        s_rst, s_ir, s_dr, s_drw;
    logic [1:0]  s_ds;
    logic [31:0] s_ia, s_da, s_dw;

    always @(posedge clk) begin
        s_rst = reset;
        s_ir = i_req;  s_ia = i_addr;
        s_dr = d_req;  s_drw = d_rw;
        s_ds = d_size; s_da = d_addr; s_dw = d_wdata;
    end

    // scoreboard: one expected transaction at a time
    bit          sb_last_d = 1;
    int          sb_who = 0;
    bit          sb_out = 0;
    bit          sb_errx = 0;
    bit          sb_kerr;
    bit          sb_f;
    int          sb_w;
    logic [31:0] sb_addr, sb_wdata;
    logic        sb_rw;
    logic [1:0]  sb_size;
    logic [3:0]  sb_exp;
    int          sb_wait = 0;
    int          sb_age = 0;
    logic [31:0] exp_ir = '0;
    logic [31:0] exp_dr = '0;
    logic [1:0]  prev_grant = '0;
    int          n_imoc = 0, n_ierr = 0, n_dmoc = 0, n_derr = 0, n_mov = 0;
    int          glog[$];

    always @(negedge clk) begin
        if (reset || s_rst) begin
            sb_last_d = 1; sb_who = 0; sb_out = 0;
            exp_ir = '0; exp_dr = '0; prev_grant = '0;
        end else begin
            if (i_moc) n_imoc++;
            if (i_err) n_ierr++;
            if (d_moc) n_dmoc++;
            if (d_err) n_derr++;
            if (m_mov) n_mov++;
            if (prev_grant == 2'b00) begin
                if (s_ir || s_dr) begin
                    sb_w = (s_ir && (!s_dr || sb_last_d)) ? 1 : 2;
                    chk("grant_winner", grant, (sb_w == 1) ? 2'b01 : 2'b10);
                    chk("prior_done", sb_out, 0);
                    glog.push_back(sb_w);
                    sb_who = sb_w; sb_age = 0; sb_wait = 0;
                    if (sb_w == 1) begin
                        sb_addr = s_ia; sb_rw = 1; sb_size = 2; sb_wdata = 0;
                        sb_f = (s_ia[1:0] != 0);
                    end else begin
                        sb_addr = s_da; sb_rw = s_drw; sb_size = s_ds;
                        sb_wdata = s_dw;
                        sb_f = (s_ds == 3) || (s_ds == 1 && s_da[0]) ||
                               (s_ds == 2 && s_da[1:0] != 0);
                    end
                    sb_errx = sb_f; sb_out = 1;
                    chk("mov_on_grant", m_mov, !sb_f);
                    if (!sb_f) sb_last_d = (sb_w == 2);
                end else begin
                    chk("idle_grant", grant, 0);
                end
            end else if (grant == 2'b00) begin
                chk("done_before_idle", sb_out, 0);
            end
            if (m_mov) begin
                chk("m_addr", m_addr, sb_addr);
                chk("m_rw", m_rw, sb_rw);
                chk("m_size", m_size, sb_size);
                if (sb_who == 2) chk("m_wdata", m_wdata, sb_wdata);
                sb_wait++;
            end
            if (i_moc || i_err || d_moc || d_err) begin
                sb_kerr = sb_errx || (TO > 0 && sb_wait >= TO);
                sb_exp = 4'b0000;
                if (sb_out && sb_who == 1) sb_exp = sb_kerr ? 4'b0100 : 4'b1000;
                if (sb_out && sb_who == 2) sb_exp = sb_kerr ? 4'b0001 : 4'b0010;
                chk("pulses", {i_moc, i_err, d_moc, d_err}, sb_exp);
                if (sb_out && !sb_kerr && sb_rw) begin
                    if (sb_who == 1) exp_ir = mem_val(sb_addr);
                    else             exp_dr = mem_val(sb_addr);
                end
                chk("i_rdata", i_rdata, exp_ir);
                chk("d_rdata", d_rdata, exp_dr);
                chk("mov_off_at_pulse", m_mov, 0);
                sb_out = 0;
            end
            if (sb_out) begin
                sb_age++;
                if (sb_age > 60) begin
                    checks++; failures++;
                    $display("FAIL pulse_timeout actual=none required=pulse");
                    sb_out = 0;
                end
            end
            prev_grant = grant;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // sel 0: any pulse, 1: m_mov, 2: grant nonzero
    task automatic wait_for(input int sel, input int bound, output int n);
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < bound) begin
            cyc(1);
            n++;
            if (sel == 0) hit = i_moc | i_err | d_moc | d_err;
            if (sel == 1) hit = m_mov;
            if (sel == 2) hit = (grant != 2'b00);
        end
        if (!hit) begin
            checks++; failures++;
            $display("FAIL wait_for%0d actual=none required=event<%0d", sel, bound);
            n = -1;
        end
    endtask

    typedef struct {
        bit          d;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        bit          err;
    } vec_t;

    vec_t tv[10];

    int n, b0, b1, b2, b3, g0;

    initial begin
        tv[0] = '{1, 1, 2'b10, 32'h0000_1002, 1};
        tv[1] = '{0, 1, 2'b10, 32'h0000_0003, 1};
        tv[2] = '{1, 1, 2'b01, 32'h0000_0101, 1};
        tv[3] = '{1, 0, 2'b11, 32'h0000_0100, 1};
        tv[4] = '{1, 1, 2'b00, 32'h0000_0003, 0};
        tv[5] = '{1, 1, 2'b01, 32'h0000_0102, 0};
        tv[6] = '{1, 0, 2'b10, 32'h0000_0104, 0};
        tv[7] = '{0, 1, 2'b10, 32'h0000_0008, 0};
        tv[8] = '{0, 1, 2'b10, 32'h0000_0002, 1};
        tv[9] = '{1, 1, 2'b10, 32'h0000_0208, 0};

        cyc(2);
        chk("rst_m_mov", m_mov, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_m_addr", m_addr, 0);
        reset = 0;
        cyc(2);

        // fetch path
        mem_lat = 2; mem_ovr_en = 1; mem_ovr = 32'h8C22_0004;
        b0 = n_imoc; b1 = n_dmoc;
        i_addr = 32'h10; i_req = 1;
        wait_for(1, 10, n);
        chk("mov_latency", n, 1);
        chk("fetch_m_addr", m_addr, 32'h10);
        chk("fetch_m_rw", m_rw, 1);
        chk("fetch_m_size", m_size, 2'b10);
        chk("fetch_grant", grant, 2'b01);
        wait_for(0, 30, n);
        chk("moc_latency", n, 3);
        chk("fetch_moc", i_moc, 1);
        chk("fetch_rdata", i_rdata, 32'h8C22_0004);
        i_req = 0;
        cyc(4);
        chk("fetch_moc_count", n_imoc - b0, 1);
        chk("fetch_no_dmoc", n_dmoc - b1, 0);
        mem_ovr_en = 0; mem_lat = 1;

        // store path
        b1 = n_dmoc;
        d_req = 1; d_rw = 0; d_size = 2'b01;
        d_addr = 32'h102; d_wdata = 32'h0000_BEEF;
        wait_for(1, 10, n);
        chk("store_m_rw", m_rw, 0);
        chk("store_m_size", m_size, 2'b01);
        chk("store_m_addr", m_addr, 32'h102);
        chk("store_m_wdata", m_wdata, 32'h0000_BEEF);
        chk("store_grant", grant, 2'b10);
        wait_for(0, 30, n);
        chk("store_moc", d_moc, 1);
        chk("store_rdata_kept", d_rdata, 32'h0);
        d_req = 0;
        cyc(4);
        chk("store_moc_count", n_dmoc - b1, 1);

        // contention from reset: I, D alternate
        reset = 1;
        cyc(2);
        reset = 0;
        g0 = glog.size();
        i_addr = 32'h20; d_rw = 1; d_size = 2'b10; d_addr = 32'h40;
        i_req = 1; d_req = 1;
        for (int k = 0; k < 120 && glog.size() < g0 + 4; k++) begin
            cyc(1);
            i_req = !(i_moc | i_err);
            d_req = !(d_moc | d_err);
        end
        i_req = 0; d_req = 0;
        chk("rr_count", (glog.size() >= g0 + 4) ? 1 : 0, 1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rr_order%0d", k),
                (glog.size() > g0 + k) ? glog[g0 + k] : 0,
                (k % 2 == 0) ? 1 : 2);
        cyc(6);

        // alignment table
        for (int v = 0; v < 10; v++) begin
            b0 = n_mov;
            if (tv[v].d) begin
                d_rw = tv[v].rw; d_size = tv[v].size;
                d_addr = tv[v].addr; d_wdata = 32'h1234_0000 + v;
                d_req = 1;
            end else begin
                i_addr = tv[v].addr; i_req = 1;
            end
            wait_for(0, 30, n);
            chk($sformatf("vec%0d_err", v), tv[v].d ? d_err : i_err, tv[v].err);
            chk($sformatf("vec%0d_moc", v), tv[v].d ? d_moc : i_moc, !tv[v].err);
            if (tv[v].err) begin
                chk($sformatf("vec%0d_err_lat", v), n, 1);
                chk($sformatf("vec%0d_no_mov", v), n_mov - b0, 0);
            end
            i_req = 0; d_req = 0;
            cyc(4);
        end

        // timeout, then a stale MOC
        mem_silent = 1;
        b0 = n_mov; b1 = n_derr; b2 = n_dmoc; b3 = n_imoc;
        d_rw = 1; d_size = 2'b10; d_addr = 32'h200; d_req = 1;
        wait_for(0, 40, n);
        chk("to_err", d_err, 1);
        chk("to_latency", n, TO + 1);
        d_req = 0;
        cyc(3);
        chk("to_mov_cycles", n_mov - b0, TO);
        chk("to_err_count", n_derr - b1, 1);
        chk("to_busy", busy, 0);
        mem_force = 1;
        cyc(2);
        mem_force = 0;
        cyc(3);
        chk("stale_no_dmoc", n_dmoc - b2, 0);
        chk("stale_no_imoc", n_imoc - b3, 0);
        chk("stale_busy", busy, 0);

        // reset in the middle of WAIT
        i_addr = 32'h30; i_req = 1;
        wait_for(1, 10, n);
        @(posedge clk);
        #2;
        reset = 1;
        #1;
        chk("rw_m_mov", m_mov, 0);
        chk("rw_grant", grant, 0);
        chk("rw_busy", busy, 0);
        chk("rw_m_addr", m_addr, 0);
        chk("rw_m_size", m_size, 0);
        chk("rw_i_rdata", i_rdata, 0);
        mem_silent = 0;
        d_rw = 1; d_size = 2'b10; d_addr = 32'h50; d_req = 1;
        cyc(1);
        reset = 0;
        wait_for(2, 10, n);
        chk("rw_first_grant", grant, 2'b01);
        wait_for(0, 30, n);
        i_req = 0; d_req = 0;
        cyc(6);

        // random traffic
        mem_lat = -1;
        for (int t = 0; t < 500; t++) begin
            cyc(1);
            if (i_req) begin
                if (i_moc | i_err) i_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                i_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                if ($urandom_range(0, 7) == 0)
                    i_addr[1:0] = 2'($urandom_range(1, 3));
                i_req = 1;
            end
            if (d_req) begin
                if (d_moc | d_err) d_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                d_rw = 1'($urandom_range(0, 1));
                d_size = ($urandom_range(0, 15) == 0) ? 2'b11
                                                       : 2'($urandom_range(0, 2));
                d_addr = {22'h1, 8'($urandom_range(0, 255)), 2'b00};
                if ($urandom_range(0, 3) == 0)
                    d_addr[1:0] = 2'($urandom_range(0, 3));
                d_wdata = $urandom;
                d_req = 1;
            end
        end
        for (int t = 0; t < 40 && (i_req || d_req); t++) begin
            cyc(1);
            if (i_moc | i_err) i_req = 0;
            if (d_moc | d_err) d_req = 0;
        end
        i_req = 0; d_req = 0;
        cyc(8);
        chk("final_busy", busy, 0);
        chk("final_grant", grant, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "bench did not finish");
    end

endmodule
